// File: rtl/lcd_pkg.sv
// Shared types and HD44780 command bytes for the 16x2 LCD driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    S_PWR_WAIT = 3'd0,
    S_INIT     = 3'd1,
    S_IDLE     = 3'd2,
    S_ADDR1    = 3'd3,
    S_ROW1     = 3'd4,
    S_ADDR2    = 3'd5,
    S_ROW2     = 3'd6
  } lcd_state_t;

  localparam logic [7:0] LCD_FUNC_SET  = 8'h38;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_ENTRY     = 8'h06;
  localparam logic [7:0] LCD_ROW1_ADDR = 8'h80;
  localparam logic [7:0] LCD_ROW2_ADDR = 8'hC0;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Power-on command sequence, indexed 0..3.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = LCD_FUNC_SET;
      2'd1:    cmd = LCD_DISP_ON;
      2'd2:    cmd = LCD_CLEAR;
      default: cmd = LCD_ENTRY;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// One HD44780 byte period (SETUP / PULSE / HOLD) plus the power-on wait,
// all timed by a single shared down-counter.
//  state    | meaning
//  TX_PWR   | power-on wait after reset, done pulses on its last cycle
//  TX_IDLE  | waiting; a cycle with start high is the SETUP cycle
//  TX_PULSE | lcd_en high for EN_CYC cycles
//  TX_HOLD  | lcd_en low for CHAR_WAIT or CLR_WAIT cycles, done on last cycle
module lcd_byte_tx import lcd_pkg::*; #(
  parameter int PWR_WAIT  = 400_000,
  parameter int EN_CYC    = 5,
  parameter int CHAR_WAIT = 500,
  parameter int CLR_WAIT  = 20_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_data,
  output logic       done
);

  localparam int CNT_W = $clog2(max_of4(PWR_WAIT, CLR_WAIT, CHAR_WAIT, EN_CYC) + 1);
  localparam logic [CNT_W-1:0] PWR_LOAD  = CNT_W'(PWR_WAIT - 1);
  localparam logic [CNT_W-1:0] EN_LOAD   = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] CHAR_LOAD = CNT_W'(CHAR_WAIT - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD  = CNT_W'(CLR_WAIT - 1);

  localparam logic [1:0] TX_PWR   = 2'd0;
  localparam logic [1:0] TX_IDLE  = 2'd1;
  localparam logic [1:0] TX_PULSE = 2'd2;
  localparam logic [1:0] TX_HOLD  = 2'd3;

  logic [1:0]       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             long_q, long_d;
  logic             setup;

  // Phase sequencing and counter reload; rs/data/long_wait latched on accept.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    rs_d   = rs_q;
    data_d = data_q;
    long_d = long_q;
    done   = 1'b0;
    case (st_q)
      TX_PWR: begin
        if (cnt_q == '0) begin
          done = 1'b1;
          st_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      TX_IDLE: begin
        if (start) begin
          rs_d   = rs;
          data_d = data;
          long_d = long_wait;
          cnt_d  = EN_LOAD;
          st_d   = TX_PULSE;
        end
      end
      TX_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d = long_q ? CLR_LOAD : CHAR_LOAD;
          st_d  = TX_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          done = 1'b1;
          st_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  // Phase state, counter and latched byte; reset restarts the power-on wait.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= TX_PWR;
      cnt_q  <= PWR_LOAD;
      rs_q   <= 1'b0;
      data_q <= 8'h00;
      long_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      rs_q   <= rs_d;
      data_q <= data_d;
      long_q <= long_d;
    end
  end

  // SETUP drives the incoming byte straight through so periods run back to back.
  always_comb begin
    setup    = (st_q == TX_IDLE) && start;
    lcd_rs   = setup ? rs : rs_q;
    lcd_data = setup ? data : data_q;
    lcd_en   = (st_q == TX_PULSE);
  end

endmodule

// File: rtl/lcd1602_driver.sv
// HD44780 16x2 driver: power-on init, then rewrites both rows from a shadow
// copy whenever the row inputs differ from the last frame written.
//  state      | meaning
//  S_PWR_WAIT | waiting out the power-on delay
//  S_INIT     | sending 38, 0C, 01, 06
//  S_IDLE     | not busy; starts a frame on first_frame or row change
//  S_ADDR1    | sending DDRAM address 0x80
//  S_ROW1     | sending shadow row1 columns 0..15
//  S_ADDR2    | sending DDRAM address 0xC0
//  S_ROW2     | sending shadow row2 columns 0..15
module lcd1602_driver import lcd_pkg::*; #(
  parameter int PWR_WAIT  = 400_000,
  parameter int EN_CYC    = 5,
  parameter int CHAR_WAIT = 500,
  parameter int CLR_WAIT  = 20_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] row1,
  input  logic [127:0] row2,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic [7:0]   lcd_data,
  output logic         busy,
  output logic         frame_done
);

  lcd_state_t   state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [3:0]   col_q, col_d;
  logic [255:0] shadow_q, shadow_d;
  logic         first_q, first_d;
  logic         frame_done_q, frame_done_d;

  logic         tx_start, tx_rs, tx_long, tx_done;
  logic [7:0]   tx_byte;
  logic [7:0]   col_ofs;

  lcd_byte_tx #(
    .PWR_WAIT (PWR_WAIT),
    .EN_CYC   (EN_CYC),
    .CHAR_WAIT(CHAR_WAIT),
    .CLR_WAIT (CLR_WAIT)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (tx_start),
    .rs       (tx_rs),
    .data     (tx_byte),
    .long_wait(tx_long),
    .lcd_rs   (lcd_rs),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data),
    .done     (tx_done)
  );

  // Byte selection for the current state; only the clear command gets the long hold.
  always_comb begin
    col_ofs  = {1'b0, col_q, 3'b000};
    tx_start = 1'b1;
    tx_rs    = 1'b0;
    tx_byte  = 8'h00;
    case (state_q)
      S_INIT:  tx_byte = init_cmd(idx_q);
      S_ADDR1: tx_byte = LCD_ROW1_ADDR;
      S_ROW1: begin
        tx_rs   = 1'b1;
        tx_byte = shadow_q[8'd255 - col_ofs -: 8];
      end
      S_ADDR2: tx_byte = LCD_ROW2_ADDR;
      S_ROW2: begin
        tx_rs   = 1'b1;
        tx_byte = shadow_q[8'd127 - col_ofs -: 8];
      end
      default: tx_start = 1'b0;
    endcase
    tx_long = !tx_rs && (tx_byte == LCD_CLEAR);
  end

  // Top sequencing: advance one byte per tx done, latch the shadow on frame start.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    col_d        = col_q;
    shadow_d     = shadow_q;
    first_d      = first_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_PWR_WAIT: begin
        if (tx_done) begin
          state_d = S_INIT;
          idx_d   = 2'd0;
        end
      end
      S_INIT: begin
        if (tx_done) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (first_q || ({row1, row2} != shadow_q)) begin
          shadow_d = {row1, row2};
          first_d  = 1'b0;
          state_d  = S_ADDR1;
        end
      end
      S_ADDR1: begin
        if (tx_done) begin
          col_d   = 4'd0;
          state_d = S_ROW1;
        end
      end
      S_ROW1: begin
        if (tx_done) begin
          col_d = col_q + 4'd1;
          if (col_q == 4'd15) state_d = S_ADDR2;
        end
      end
      S_ADDR2: begin
        if (tx_done) begin
          col_d   = 4'd0;
          state_d = S_ROW2;
        end
      end
      S_ROW2: begin
        if (tx_done) begin
          col_d = col_q + 4'd1;
          if (col_q == 4'd15) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end
        end
      end
      default: state_d = S_PWR_WAIT;
    endcase
  end

  // Sequencer registers; reset forces a full re-init and a fresh first frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_PWR_WAIT;
      idx_q        <= 2'd0;
      col_q        <= 4'd0;
      shadow_q     <= '0;
      first_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      col_q        <= col_d;
      shadow_q     <= shadow_d;
      first_q      <= first_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign lcd_rw     = 1'b0;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd1602_driver.sv
// Scoreboard bench for lcd1602_driver: expected {rs,data} bytes are queued when
// stimulus is applied and popped on every lcd_en rise; a monitor also checks
// byte-period timing.
module tb_lcd1602_driver;

  localparam int PWR_WAIT  = 20;
  localparam int EN_CYC    = 2;
  localparam int CHAR_WAIT = 4;
  localparam int CLR_WAIT  = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] row1;
  logic [127:0] row2;
  logic         lcd_rs, lcd_rw, lcd_en, busy, frame_done;
  logic [7:0]   lcd_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [8:0] exp_q[$];
  int         rise_q[$];

  lcd1602_driver #(
    .PWR_WAIT (PWR_WAIT),
    .EN_CYC   (EN_CYC),
    .CHAR_WAIT(CHAR_WAIT),
    .CLR_WAIT (CLR_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row1      (row1),
    .row2      (row2),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_data  (lcd_data),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: scoreboard pop on each en rise plus setup/pulse/hold stability.
  initial begin : monitor
    logic       prev_en, prev_rs, cur_rs;
    logic [7:0] prev_data, cur_data;
    logic [8:0] e;
    int         en_len, hold_left, cur_w;
    prev_en = 1'b0; prev_rs = 1'b0; prev_data = 8'h00;
    cur_rs = 1'b0; cur_data = 8'h00; en_len = 0; hold_left = 0; cur_w = CHAR_WAIT;
    forever begin
      @(negedge clk);
      if (rst) begin
        en_len = 0;
        hold_left = 0;
        prev_en = 1'b0;
      end else begin
        if (lcd_en && !prev_en) begin
          rise_q.push_back(cyc);
          checks++;
          if (lcd_rs !== prev_rs || lcd_data !== prev_data || lcd_rw !== 1'b0) begin
            errors++;
            $display("FAIL setup_stable cyc=%0d: rs=%b data=%h rw=%b, setup cycle had rs=%b data=%h rw=0",
                     cyc, lcd_rs, lcd_data, lcd_rw, prev_rs, prev_data);
          end
          e = {lcd_rs, lcd_data};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse cyc=%0d: got rs=%b data=%h, no byte expected",
                     cyc, lcd_rs, lcd_data);
          end else begin
            e = exp_q.pop_front();
            if ({lcd_rs, lcd_data} !== e) begin
              errors++;
              $display("FAIL byte cyc=%0d: got rs=%b data=%h, expected rs=%b data=%h",
                       cyc, lcd_rs, lcd_data, e[8], e[7:0]);
            end
          end
          cur_rs = lcd_rs;
          cur_data = lcd_data;
          cur_w = (!e[8] && e[7:0] == 8'h01) ? CLR_WAIT : CHAR_WAIT;
          en_len = 1;
          hold_left = 0;
        end else if (lcd_en) begin
          en_len++;
          checks++;
          if (lcd_rs !== cur_rs || lcd_data !== cur_data) begin
            errors++;
            $display("FAIL pulse_stable cyc=%0d: rs=%b data=%h, expected rs=%b data=%h",
                     cyc, lcd_rs, lcd_data, cur_rs, cur_data);
          end
        end else if (prev_en) begin
          checks++;
          if (en_len != EN_CYC) begin
            errors++;
            $display("FAIL en_width cyc=%0d: en high %0d cycles, expected %0d", cyc, en_len, EN_CYC);
          end
          hold_left = cur_w;
        end
        if (!lcd_en && hold_left > 0) begin
          checks++;
          if (lcd_rs !== cur_rs || lcd_data !== cur_data) begin
            errors++;
            $display("FAIL hold_stable cyc=%0d: rs=%b data=%h, expected rs=%b data=%h",
                     cyc, lcd_rs, lcd_data, cur_rs, cur_data);
          end
          hold_left--;
        end
        prev_en = lcd_en;
      end
      prev_rs = lcd_rs;
      prev_data = lcd_data;
    end
  end

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
  endtask

  task automatic push_frame(input logic [127:0] r1, input logic [127:0] r2);
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, r1[127 - 8*i -: 8]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, r2[127 - 8*i -: 8]});
  endtask

  task automatic wait_rises(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (rise_q.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (rise_q.size() < n) begin
      errors++; checks++;
      $display("FAIL %s_timeout: saw %0d en rises, required %0d", tag, rise_q.size(), n);
    end
  endtask

  task automatic wait_frame_done(output int fd, output logic busy_at, output logic busy_before,
                                 input int budget);
    int k;
    logic b_prev;
    fd = -1; busy_at = 1'bx; busy_before = 1'bx; b_prev = 1'bx; k = 0;
    while (fd < 0 && k < budget) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        fd = cyc; busy_at = busy; busy_before = b_prev;
      end
      b_prev = busy;
      k++;
    end
    if (fd < 0) begin
      errors++; checks++;
      $display("FAIL frame_done_timeout: no frame_done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    int rel;
    rst = 1'b1;
    row1 = "HANGMAN_________";
    row2 = {16{8'h5F}};
    @(posedge clk); @(posedge clk); #1;
    checks++; if (lcd_rs !== 1'b0)     begin errors++; $display("FAIL rst_rs: got %b, expected 0", lcd_rs); end
    checks++; if (lcd_rw !== 1'b0)     begin errors++; $display("FAIL rst_rw: got %b, expected 0", lcd_rw); end
    checks++; if (lcd_en !== 1'b0)     begin errors++; $display("FAIL rst_en: got %b, expected 0", lcd_en); end
    checks++; if (lcd_data !== 8'h00)  begin errors++; $display("FAIL rst_data: got %h, expected 00", lcd_data); end
    checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL rst_busy: got %b, expected 1", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b, expected 0", frame_done); end
    push_init();
    rst = 1'b0;
    rel = cyc;
    wait_rises(4, 200, "init");
    if (rise_q.size() >= 4) begin
      checks++;
      if (rise_q[0] - rel != 21) begin
        errors++; $display("FAIL first_en_rise: %0d cycles after release, expected 21", rise_q[0] - rel);
      end
      checks++;
      if (rise_q[1] - rise_q[0] != 7 || rise_q[2] - rise_q[1] != 7) begin
        errors++; $display("FAIL init_char_period: gaps %0d,%0d, expected 7,7",
                           rise_q[1] - rise_q[0], rise_q[2] - rise_q[1]);
      end
      checks++;
      if (rise_q[3] - rise_q[2] != 13) begin
        errors++; $display("FAIL clear_period: gap %0d, expected 13", rise_q[3] - rise_q[2]);
      end
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL init_busy: got %b, expected 1", busy); end
  endtask

  task automatic test_first_frame();
    int base, fd;
    logic b_at, b_before;
    base = rise_q.size();
    push_frame(row1, row2);
    wait_frame_done(fd, b_at, b_before, 600);
    checks++;
    if (rise_q.size() - base != 34) begin
      errors++; $display("FAIL frame_pulses: got %0d, expected 34", rise_q.size() - base);
    end
    if (fd >= 0 && rise_q.size() > base) begin
      checks++;
      if (fd - (rise_q[base] - 1) != 238) begin
        errors++; $display("FAIL frame_done_latency: %0d cycles after 0x80 setup, expected 238",
                           fd - (rise_q[base] - 1));
      end
      checks++;
      if (b_at !== 1'b0 || b_before !== 1'b1) begin
        errors++; $display("FAIL busy_fall: busy=%b at frame_done, %b before, expected 0 and 1", b_at, b_before);
      end
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0) begin
        errors++; $display("FAIL frame_done_width: got %b one cycle later, expected 0", frame_done);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL frame_leftover: %0d expected bytes not seen, expected 0", exp_q.size());
    end
  endtask

  task automatic test_no_change();
    int p0, bad;
    p0 = rise_q.size();
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (busy !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_busy: %0d cycles busy/frame_done, expected 0", bad); end
    checks++;
    if (rise_q.size() != p0) begin
      errors++; $display("FAIL idle_pulses: got %0d pulses, expected 0", rise_q.size() - p0);
    end
  endtask

  task automatic test_mid_frame();
    int base, fd1, fd2;
    logic b1, b2;
    logic [127:0] r2_old;
    base = rise_q.size();
    r2_old = row2;
    row1 = "MIDFRAME_TEST___";
    push_frame(row1, r2_old);
    wait_rises(base + 3, 100, "mid_start");
    row2[127:120] = 8'h41;
    push_frame(row1, row2);
    wait_frame_done(fd1, b1, b2, 400);
    wait_frame_done(fd2, b1, b2, 400);
    checks++;
    if (rise_q.size() - base != 68) begin
      errors++; $display("FAIL mid_pulses: got %0d, expected 68", rise_q.size() - base);
    end else if (fd1 >= 0) begin
      checks++;
      if (rise_q[base + 34] - 1 != fd1 + 1) begin
        errors++; $display("FAIL restart_gap: 2nd frame setup %0d cycles after frame_done, expected 1",
                           rise_q[base + 34] - 1 - fd1);
      end
      checks++;
      if (fd2 - fd1 != 239) begin
        errors++; $display("FAIL back_to_back: frame_done spacing %0d, expected 239", fd2 - fd1);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL mid_leftover: %0d expected bytes not seen, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int base, rel, fd;
    logic b1, b2;
    base = rise_q.size();
    row1 = "RESET_MID_FRAME_";
    push_frame(row1, row2);
    wait_rises(base + 6, 100, "rst_mid_start");
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (lcd_en !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid: en=%b busy=%b, expected en=0 busy=1", lcd_en, busy);
    end
    exp_q.delete();
    @(posedge clk); #1;
    push_init();
    push_frame(row1, row2);
    rst = 1'b0;
    rel = cyc;
    base = rise_q.size();
    wait_rises(base + 1, 100, "rst_reinit");
    if (rise_q.size() > base) begin
      checks++;
      if (rise_q[base] - rel != 21) begin
        errors++; $display("FAIL reinit_en_rise: %0d cycles after release, expected 21", rise_q[base] - rel);
      end
    end
    wait_frame_done(fd, b1, b2, 600);
    checks++;
    if (rise_q.size() - base != 38) begin
      errors++; $display("FAIL reinit_pulses: got %0d, expected 38", rise_q.size() - base);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL reinit_leftover: %0d expected bytes not seen, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_no_change();
    test_mid_frame();
    test_reset_mid();
    repeat (20) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
